mem_fu_scheduler: RTL and testbench
===================================

MEM_FU_SCHEDULER -- requirements
Module: mem_fu_scheduler

Interface
REQ-001 Parameter TAG_W, 5, width of request/result tag.
REQ-002 Parameter TIMEOUT, 8, max cycles in WAIT before abort; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0/req1  input  1  request valid from port 0 (load RS) / port 1 (store RS); held until ack.
REQ-006 mem_w0/mem_w1  input  1  store flag per port.
REQ-007 bhw0/bhw1  input  3  size/sign code per port, passed through unchanged.
REQ-008 rs1_0/rs1_1, rs2_0/rs2_1, imm0/imm1  input  32 each  operands per port.
REQ-009 tag0/tag1  input  TAG_W  requester tag per port.
REQ-010 ack0/ack1  output  1  one-cycle grant pulse; operands consumed that cycle.
REQ-011 fu_en  output  1  issue strobe to memory FU.
REQ-012 fu_mem_w, fu_bhw[2:0], fu_rs1[31:0], fu_rs2[31:0], fu_imm[31:0]  output  operands to memory FU, registered.
REQ-013 fu_finish  input  1  FU completion pulse; fu_data  input  32  FU read data.
REQ-014 res_valid  output  1  one-cycle result pulse.
REQ-015 res_tag  output  TAG_W; res_src  output  1 (granted port); res_data  output  32; res_err  output  1 (timeout).
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; one-hot or binary at implementer's choice, no other reachable states.
REQ-018 IDLE: if any req, select winner, pulse its ack, latch mem_w/bhw/rs1/rs2/imm/tag and src, go ISSUE; else stay.
REQ-019 Arbitration round-robin: 1-bit pointer prio; both req -> port prio wins; single req -> that port wins regardless of prio.
REQ-020 prio set to NOT(winner) on every grant.
REQ-021 ISSUE: fu_en=1 for exactly this one cycle; fu_* operand outputs stable from ISSUE through end of WAIT; go WAIT.
REQ-022 WAIT: cycle counter cnt starts at 0 on entry, increments each WAIT cycle.
REQ-023 WAIT with fu_finish=1: capture fu_data into res_data (stores: res_data=0), go DONE.
REQ-024 WAIT with fu_finish=0 and cnt==TIMEOUT-1: abort, res_err=1, res_data=0, go DONE.
REQ-025 fu_finish in any state other than WAIT ignored.
REQ-026 DONE: res_valid=1, res_tag/res_src/res_err valid this cycle only qualified by res_valid; go IDLE.
REQ-027 Nominal latency with FU finish 2 cycles after fu_en: ack cycle N, fu_en N+1, finish N+3, res_valid N+4; next ack earliest N+5.
REQ-028 No grant while busy; req held during busy gets no ack and no state change.
REQ-029 ack0 and ack1 never high in the same cycle; fu_en never high outside ISSUE.

Reset
REQ-030 rst asserted: immediately state=IDLE, prio=0, cnt=0, all outputs 0, regardless of clock.
REQ-031 rst mid-operation (ISSUE/WAIT/DONE) drops the in-flight op: no res_valid produced for it after rst deasserts.
REQ-032 First posedge after rst deassert evaluates IDLE normally.

Verification
REQ-033 Single load port 0, tag=3, FU returns 0xDEADBEEF 2 cycles after fu_en -> ack0 cycle N, fu_en N+1, res_valid N+4 with res_tag=3, res_src=0, res_data=0xDEADBEEF, res_err=0.
REQ-034 req0 and req1 both held continuously from reset -> grants alternate 0,1,0,1; prio after 4 grants = 0; no double ack.
REQ-035 Store on port 1 (mem_w1=1, rs2_1=0x12345678) -> fu_mem_w=1, fu_rs2=0x12345678 stable through WAIT; res_valid with res_data=0, res_src=1.
REQ-036 fu_finish never asserted, TIMEOUT=8 -> res_valid with res_err=1 exactly 8 WAIT cycles after entry; busy drops next cycle.
REQ-037 rst pulsed during WAIT then released, late fu_finish arrives -> no res_valid, busy=0, next req0 granted normally with prio=0.
REQ-038 Spurious fu_finish in IDLE and ISSUE -> no res_valid, FSM unaffected.

Source files
------------

// File: rtl/mem_fu_scheduler.sv
// Two-port round-robin scheduler feeding a single memory functional unit.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
module mem_fu_scheduler #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             mem_w0,
  input  logic             mem_w1,
  input  logic [2:0]       bhw0,
  input  logic [2:0]       bhw1,
  input  logic [31:0]      rs1_0,
  input  logic [31:0]      rs1_1,
  input  logic [31:0]      rs2_0,
  input  logic [31:0]      rs2_1,
  input  logic [31:0]      imm0,
  input  logic [31:0]      imm1,
  input  logic [TAG_W-1:0] tag0,
  input  logic [TAG_W-1:0] tag1,
  output logic             ack0,
  output logic             ack1,
  output logic             fu_en,
  output logic             fu_mem_w,
  output logic [2:0]       fu_bhw,
  output logic [31:0]      fu_rs1,
  output logic [31:0]      fu_rs2,
  output logic [31:0]      fu_imm,
  input  logic             fu_finish,
  input  logic [31:0]      fu_data,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic             prio;
  logic [7:0]       cnt;
  logic             any_req;
  logic             win;
  logic             grant;
  logic             timeout_hit;
  logic [TAG_W-1:0] tag_q;
  logic             src_q;

  always_comb begin
    any_req     = req0 | req1;
    // With both ports requesting the pointer decides; otherwise the lone requester wins.
    win         = (req0 & req1) ? prio : req1;
    grant       = (state == S_IDLE) & any_req & ~rst;
    timeout_hit = (cnt == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (fu_finish || timeout_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      cnt      <= '0;
      fu_mem_w <= 1'b0;
      fu_bhw   <= '0;
      fu_rs1   <= '0;
      fu_rs2   <= '0;
      fu_imm   <= '0;
      tag_q    <= '0;
      src_q    <= 1'b0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            prio     <= ~win;
            src_q    <= win;
            fu_mem_w <= win ? mem_w1 : mem_w0;
            fu_bhw   <= win ? bhw1   : bhw0;
            fu_rs1   <= win ? rs1_1  : rs1_0;
            fu_rs2   <= win ? rs2_1  : rs2_0;
            fu_imm   <= win ? imm1   : imm0;
            tag_q    <= win ? tag1   : tag0;
            res_data <= '0;
            res_err  <= 1'b0;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (fu_finish) begin
            res_data <= fu_mem_w ? '0 : fu_data;
            res_err  <= 1'b0;
          end else if (timeout_hit) begin
            res_data <= '0;
            res_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack0      = grant & ~win;
  assign ack1      = grant & win;
  assign fu_en     = (state == S_ISSUE);
  assign res_valid = (state == S_DONE);
  assign res_tag   = tag_q;
  assign res_src   = src_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_fu_scheduler.sv
// Directed bench for mem_fu_scheduler with hand-computed expectations.
module tb_mem_fu_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, mem_w0, mem_w1;
  logic [2:0]  bhw0, bhw1;
  logic [31:0] rs1_0, rs1_1, rs2_0, rs2_1, imm0, imm1;
  logic [4:0]  tag0, tag1;
  logic        ack0, ack1, fu_en, fu_mem_w;
  logic [2:0]  fu_bhw;
  logic [31:0] fu_rs1, fu_rs2, fu_imm;
  logic        fu_finish;
  logic [31:0] fu_data;
  logic        res_valid;
  logic [4:0]  res_tag;
  logic        res_src;
  logic [31:0] res_data;
  logic        res_err, busy;

  int n_total = 0;
  int n_pass  = 0;

  mem_fu_scheduler #(.TAG_W(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .mem_w0(mem_w0), .mem_w1(mem_w1),
    .bhw0(bhw0), .bhw1(bhw1), .rs1_0(rs1_0), .rs1_1(rs1_1),
    .rs2_0(rs2_0), .rs2_1(rs2_1), .imm0(imm0), .imm1(imm1),
    .tag0(tag0), .tag1(tag1), .ack0(ack0), .ack1(ack1),
    .fu_en(fu_en), .fu_mem_w(fu_mem_w), .fu_bhw(fu_bhw),
    .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_imm(fu_imm),
    .fu_finish(fu_finish), .fu_data(fu_data),
    .res_valid(res_valid), .res_tag(res_tag), .res_src(res_src),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req0 = 0; req1 = 0; mem_w0 = 0; mem_w1 = 0; bhw0 = 0; bhw1 = 0;
    rs1_0 = 0; rs1_1 = 0; rs2_0 = 0; rs2_1 = 0; imm0 = 0; imm1 = 0;
    tag0 = 0; tag1 = 0; fu_finish = 0; fu_data = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    int grants[5];
    int ng;

    // reset state
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", {30'b0, ack1, ack0}, 0);
    chk("rst_fu_en", 32'(fu_en), 0);
    chk("rst_res_valid", 32'(res_valid), 0);

    // single load on port 0, FU answers 2 cycles after fu_en
    req0 = 1; tag0 = 5'd3; bhw0 = 3'b101; rs1_0 = 32'h1000; imm0 = 32'h10; #1;
    chk("ld_ack0", {30'b0, ack1, ack0}, 32'b01);
    tick(); req0 = 0; #1;                                  // N+1
    chk("ld_fu_en", 32'(fu_en), 1);
    chk("ld_fu_rs1", fu_rs1, 32'h1000);
    chk("ld_fu_bhw", 32'(fu_bhw), 32'b101);
    chk("ld_busy", 32'(busy), 1);
    tick(); #1;                                            // N+2
    chk("ld_fu_en_off", 32'(fu_en), 0);
    tick(); fu_finish = 1; fu_data = 32'hDEADBEEF; #1;     // N+3
    chk("ld_no_early_res", 32'(res_valid), 0);
    tick(); fu_finish = 0; fu_data = 0; #1;                // N+4
    chk("ld_res_valid", 32'(res_valid), 1);
    chk("ld_res_tag", 32'(res_tag), 3);
    chk("ld_res_src", 32'(res_src), 0);
    chk("ld_res_data", res_data, 32'hDEADBEEF);
    chk("ld_res_err", 32'(res_err), 0);
    tick(); #1;                                            // N+5
    chk("ld_idle", {30'b0, busy, res_valid}, 0);

    // spurious finish in IDLE then ISSUE
    fu_finish = 1; fu_data = 32'h55; tick(); fu_finish = 0; #1;
    chk("sp_idle", {30'b0, busy, res_valid}, 0);
    req0 = 1; tag0 = 5'd7; #1;
    chk("sp_ack0", 32'(ack0), 1);
    tick(); req0 = 0; fu_finish = 1; fu_data = 32'h66; #1; // ISSUE
    chk("sp_issue_en", 32'(fu_en), 1);
    tick(); fu_finish = 0; #1;                             // WAIT cnt0
    chk("sp_issue_ignored", {30'b0, busy, res_valid}, 32'b10);
    fu_finish = 1; fu_data = 32'h77;
    tick(); fu_finish = 0; #1;                             // DONE
    chk("sp_res", {res_valid, res_err, 30'b0} | res_data, 32'h8000_0077);

    // both ports requesting from reset alternate 0,1,0,1 then 0 again
    do_reset();
    req0 = 1; req1 = 1; fu_finish = 1; ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (ack0 && ack1) chk("rr_double_ack", {30'b0, ack1, ack0}, 32'b01);
      else if (ack0 || ack1) begin
        grants[ng] = ack1 ? 1 : 0;
        ng++;
      end
      tick();
    end
    chk("rr_count", 32'(ng), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));

    // store on port 1; operands held through WAIT
    do_reset();
    req1 = 1; mem_w1 = 1; rs2_1 = 32'h12345678; tag1 = 5'd9; #1;
    chk("st_ack1", {30'b0, ack1, ack0}, 32'b10);
    tick(); req1 = 0; rs2_1 = 32'hFFFF0000; mem_w1 = 0; #1;  // ISSUE
    chk("st_fu_mem_w", 32'(fu_mem_w), 1);
    chk("st_fu_rs2", fu_rs2, 32'h12345678);
    tick(); #1;                                             // WAIT cnt0
    chk("st_rs2_wait0", fu_rs2, 32'h12345678);
    tick(); fu_finish = 1; fu_data = 32'hABCD; #1;          // WAIT cnt1
    chk("st_rs2_wait1", {fu_rs2[30:0], fu_mem_w}, {31'h12345678, 1'b1});
    tick(); fu_finish = 0; #1;                              // DONE
    chk("st_res_valid", 32'(res_valid), 1);
    chk("st_res_data", res_data, 0);
    chk("st_res_src", 32'(res_src), 1);
    chk("st_res_tag", 32'(res_tag), 9);

    // timeout: no finish, abort after 8 WAIT cycles
    do_reset();
    req0 = 1; tag0 = 5'd12; #1;
    chk("to_ack0", 32'(ack0), 1);
    tick(); req0 = 0;                                       // ISSUE
    tick();                                                 // WAIT entry, cnt0
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("to_wait%0d", k), {30'b0, busy, res_valid}, 32'b10);
    end
    tick();                                                 // entry + 8
    chk("to_res_valid", 32'(res_valid), 1);
    chk("to_res_err", 32'(res_err), 1);
    chk("to_res_data", res_data, 0);
    chk("to_res_tag", 32'(res_tag), 12);
    tick();
    chk("to_busy_drop", 32'(busy), 0);

    // reset during WAIT drops the op; late finish ignored
    do_reset();
    req1 = 1; rs1_1 = 32'hCAFE; #1;
    chk("rw_ack1", 32'(ack1), 1);
    tick(); req1 = 0;
    tick(); tick();                                         // WAIT cnt1
    #2 rst = 1; #1;
    chk("rw_async_busy", {29'b0, busy, fu_en, res_valid}, 0);
    chk("rw_async_rs1", fu_rs1, 0);
    tick(); rst = 0; fu_finish = 1; fu_data = 32'h1234;
    tick(); fu_finish = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rw_no_res%0d", k), {30'b0, busy, res_valid}, 0);
      tick();
    end
    req0 = 1; req1 = 1; #1;
    chk("rw_prio0", {30'b0, ack1, ack0}, 32'b01);
    tick(); quiet();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
